alu_sru: RTL and testbench



---
 rtl/alu_sru_pkg.sv | 28 ++
 rtl/alu_sru_if.sv | 29 ++
 rtl/alu_sru_step.sv | 37 +++
 rtl/alu_sru.sv | 100 ++++++++++
 tb/tb_alu_sru.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sru_pkg.sv
// Shared types for the ALU shift/rotate unit.
// Optional ASR mode is enabled by defining ALU_SRU_ASR_EN.
package alu_sru_pkg;

    typedef enum logic [2:0] {
        SRU_SHL = 3'b000,
        SRU_SHR = 3'b001,
        SRU_ROL = 3'b010,
        SRU_ROR = 3'b011,
        SRU_ASR = 3'b100
    } sru_mode_e;

    typedef enum logic [1:0] {
        SRU_IDLE = 2'b00,
        SRU_RUN  = 2'b01,
        SRU_DONE = 2'b10
    } sru_state_e;

    // Unsupported modes start nothing, exactly like a zero count.
    function automatic logic sru_mode_valid(input logic [2:0] m);
`ifdef ALU_SRU_ASR_EN
        return (m[2] == 1'b0) || (m == SRU_ASR);
`else
        return (m[2] == 1'b0);
`endif
    endfunction

endpackage

// File: rtl/alu_sru_if.sv
// IBus / microcode-side signal bundle for alu_sru; master is the sequencer side.
interface alu_sru_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
);
    logic [WIDTH-1:0] ibus_in;
    logic             nwrite_alu_b;
    logic             naction_sru;
    logic [CNTW-1:0]  count;
    logic [2:0]       mode;
    logic             fl;
    logic             nread_alu_b;
    logic [WIDTH-1:0] ibus_out;
    logic             ibus_oe;
    logic             flin_sru;
    logic             nflagwe_sru;
    logic             busy;
    logic             nwait_sru;

    modport master (
        output ibus_in, nwrite_alu_b, naction_sru, count, mode, fl, nread_alu_b,
        input  ibus_out, ibus_oe, flin_sru, nflagwe_sru, busy, nwait_sru
    );

    modport slave (
        input  ibus_in, nwrite_alu_b, naction_sru, count, mode, fl, nread_alu_b,
        output ibus_out, ibus_oe, flin_sru, nflagwe_sru, busy, nwait_sru
    );
endinterface

// File: rtl/alu_sru_step.sv
// Combinational single-bit shift/rotate step: {r, lk, mode} -> {r', lk'}.
// ASR step exists only when ALU_SRU_ASR_EN is defined.
module alu_sru_step
    import alu_sru_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             lk,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] r_nxt,
    output logic             lk_nxt
);
    always_comb begin
        r_nxt  = r;
        lk_nxt = lk;
        case (mode)
            SRU_SHL: begin
                lk_nxt = r[WIDTH-1];
                r_nxt  = {r[WIDTH-2:0], 1'b0};
            end
            SRU_SHR: begin
                lk_nxt = r[0];
                r_nxt  = {1'b0, r[WIDTH-1:1]};
            end
            SRU_ROL: {lk_nxt, r_nxt} = {r, lk};
            SRU_ROR: {r_nxt, lk_nxt} = {lk, r};
`ifdef ALU_SRU_ASR_EN
            SRU_ASR: begin
                lk_nxt = r[0];
                r_nxt  = {r[WIDTH-1], r[WIDTH-1:1]};
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_sru.sv
// Iterative shift/rotate unit: one bit step per clk4 edge, link strobe in DONE.
// Mode 100 (ASR) is available only when ALU_SRU_ASR_EN is defined.
module alu_sru
    import alu_sru_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
) (
    input logic      clk4,
    input logic      reset,
    alu_sru_if.slave bus
);
    sru_state_e       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             lk_q, lk_d;
    logic [CNTW-1:0]  rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             nflagwe_q, nflagwe_d;
    logic             flin_q, flin_d;

    logic [WIDTH-1:0] step_r;
    logic             step_lk;

    alu_sru_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .lk     (lk_q),
        .mode   (mode_q),
        .r_nxt  (step_r),
        .lk_nxt (step_lk)
    );

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        lk_d      = lk_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        nflagwe_d = 1'b1;
        flin_d    = flin_q;
        case (state_q)
            SRU_IDLE: begin
                // A load on the same edge as a start takes priority and cancels it.
                if (!bus.nwrite_alu_b) begin
                    r_d = bus.ibus_in;
                end else if (!bus.naction_sru && (bus.count != '0) &&
                             sru_mode_valid(bus.mode)) begin
                    state_d = SRU_RUN;
                    rem_d   = bus.count;
                    mode_d  = bus.mode;
                    lk_d    = bus.fl;
                    busy_d  = 1'b1;
                end
            end
            SRU_RUN: begin
                r_d   = step_r;
                lk_d  = step_lk;
                rem_d = rem_q - CNTW'(1);
                if (rem_q == CNTW'(1)) begin
                    state_d   = SRU_DONE;
                    busy_d    = 1'b0;
                    nflagwe_d = 1'b0;
                    flin_d    = step_lk;
                end
            end
            SRU_DONE: state_d = SRU_IDLE;
            default:  state_d = SRU_IDLE;
        endcase
    end

    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            state_q   <= SRU_IDLE;
            r_q       <= '0;
            lk_q      <= 1'b0;
            rem_q     <= '0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            nflagwe_q <= 1'b1;
            flin_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            lk_q      <= lk_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            nflagwe_q <= nflagwe_d;
            flin_q    <= flin_d;
        end
    end

    assign bus.ibus_out    = r_q;
    assign bus.ibus_oe     = ~bus.nread_alu_b;
    assign bus.flin_sru    = flin_q;
    assign bus.nflagwe_sru = nflagwe_q;
    assign bus.busy        = busy_q;
    assign bus.nwait_sru   = ~busy_q;
endmodule

// File: tb/tb_alu_sru.sv
// Directed self-checking bench for alu_sru; count widened to 5 bits to reach 17.
module tb_alu_sru;
    import alu_sru_pkg::*;

    logic clk4 = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk4 = ~clk4;

    alu_sru_if #(.WIDTH(16), .CNTW(5)) bus ();

    alu_sru #(.WIDTH(16), .CNTW(5)) dut (
        .clk4  (clk4),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk4);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        bus.ibus_in      = v;
        bus.nwrite_alu_b = 1'b0;
        tick();
        bus.nwrite_alu_b = 1'b1;
    endtask

    task automatic start(input logic [2:0] m, input logic [4:0] c, input logic f);
        bus.mode        = m;
        bus.count       = c;
        bus.fl          = f;
        bus.naction_sru = 1'b0;
        tick();
        bus.naction_sru = 1'b1;
    endtask

    // Bounded wait: counts cycles with busy high, gives up after 64.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            cycles++;
            tick();
        end
    endtask

    task automatic do_op(input logic [2:0] m, input logic [4:0] c, input logic f,
                         output int cycles, output logic nfw_done, output logic nfw_after,
                         output logic [15:0] r, output logic fo);
        start(m, c, f);
        wait_done(cycles);
        nfw_done = bus.nflagwe_sru;
        r        = bus.ibus_out;
        fo       = bus.flin_sru;
        tick();
        nfw_after = bus.nflagwe_sru;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.ibus_out !== 16'h0000) begin errors++; $display("FAIL reset_r: got %h want 0000", bus.ibus_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.nwait_sru !== 1'b1) begin errors++; $display("FAIL reset_nwait: got %b want 1", bus.nwait_sru); end
        checks++; if (bus.nflagwe_sru !== 1'b1) begin errors++; $display("FAIL reset_nflagwe: got %b want 1", bus.nflagwe_sru); end
        checks++; if (bus.flin_sru !== 1'b0) begin errors++; $display("FAIL reset_flin: got %b want 0", bus.flin_sru); end
        checks++; if (bus.ibus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.ibus_oe); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_shl();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'h8001);
        do_op(SRU_SHL, 5'd1, 1'b0, cyc, nd, na, r, fo);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL shl_busy: got %0d want 1", cyc); end
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL shl_r: got %h want 0002", r); end
        checks++; if (fo !== 1'b1) begin errors++; $display("FAIL shl_flin: got %b want 1", fo); end
        checks++; if (nd !== 1'b0) begin errors++; $display("FAIL shl_strobe: got %b want 0", nd); end
        checks++; if (na !== 1'b1) begin errors++; $display("FAIL shl_strobe_end: got %b want 1", na); end
        tick();
        checks++; if (bus.flin_sru !== 1'b1) begin errors++; $display("FAIL shl_flin_hold: got %b want 1", bus.flin_sru); end
    endtask

    task automatic test_shr();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'h0006);
        do_op(SRU_SHR, 5'd2, 1'b0, cyc, nd, na, r, fo);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL shr_r: got %h want 0001", r); end
        checks++; if (fo !== 1'b1) begin errors++; $display("FAIL shr_flin: got %b want 1", fo); end
    endtask

    task automatic test_ror();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'h0001);
        do_op(SRU_ROR, 5'd2, 1'b1, cyc, nd, na, r, fo);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL ror_busy: got %0d want 2", cyc); end
        checks++; if (r !== 16'hC000) begin errors++; $display("FAIL ror_r: got %h want c000", r); end
        checks++; if (fo !== 1'b0) begin errors++; $display("FAIL ror_flin: got %b want 0", fo); end
        checks++; if (nd !== 1'b0) begin errors++; $display("FAIL ror_strobe: got %b want 0", nd); end
    endtask

    task automatic test_rol17();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'h1234);
        do_op(SRU_ROL, 5'd17, 1'b0, cyc, nd, na, r, fo);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL rol17_busy: got %0d want 17", cyc); end
        checks++; if (r !== 16'h1234) begin errors++; $display("FAIL rol17_r: got %h want 1234", r); end
        checks++; if (fo !== 1'b0) begin errors++; $display("FAIL rol17_flin: got %b want 0", fo); end
    endtask

    task automatic test_shl_saturate();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'hFFFF);
        do_op(SRU_SHL, 5'd17, 1'b1, cyc, nd, na, r, fo);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL shl17_r: got %h want 0000", r); end
        checks++; if (fo !== 1'b0) begin errors++; $display("FAIL shl17_flin: got %b want 0", fo); end
    endtask

    task automatic test_ignore_and_back_to_back();
        int cyc;
        load(16'h00F0);
        start(SRU_ROL, 5'd4, 1'b0);
        bus.naction_sru  = 1'b0;
        bus.nwrite_alu_b = 1'b0;
        bus.ibus_in      = 16'hFFFF;
        bus.mode         = SRU_SHR;
        bus.count        = 5'd1;
        bus.nread_alu_b  = 1'b0;
        tick();
        bus.naction_sru  = 1'b1;
        bus.nwrite_alu_b = 1'b1;
        checks++; if (bus.ibus_out !== 16'h01E0) begin errors++; $display("FAIL run_partial: got %h want 01e0", bus.ibus_out); end
        checks++; if (bus.ibus_oe !== 1'b1) begin errors++; $display("FAIL run_oe: got %b want 1", bus.ibus_oe); end
        bus.nread_alu_b = 1'b1;
        wait_done(cyc);
        checks++; if (cyc + 1 !== 4) begin errors++; $display("FAIL ign_busy: got %0d want 4", cyc + 1); end
        checks++; if (bus.ibus_out !== 16'h0F00) begin errors++; $display("FAIL ign_r: got %h want 0f00", bus.ibus_out); end
        checks++; if (bus.nflagwe_sru !== 1'b0) begin errors++; $display("FAIL ign_strobe: got %b want 0", bus.nflagwe_sru); end
        // start held low through DONE (ignored) and into IDLE (accepted)
        bus.mode = SRU_SHL; bus.count = 5'd1; bus.fl = 1'b0; bus.naction_sru = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_start: got busy %b want 0", bus.busy); end
        tick();
        bus.naction_sru = 1'b1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.ibus_out !== 16'h1E00) begin errors++; $display("FAIL b2b_r: got %h want 1e00", bus.ibus_out); end
        checks++; if (bus.nflagwe_sru !== 1'b0) begin errors++; $display("FAIL b2b_strobe: got %b want 0", bus.nflagwe_sru); end
        tick();
    endtask

    task automatic test_count_zero();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'hA5A5);
        do_op(SRU_SHL, 5'd0, 1'b1, cyc, nd, na, r, fo);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL cnt0_busy: got %0d want 0", cyc); end
        checks++; if (nd !== 1'b1 || na !== 1'b1) begin errors++; $display("FAIL cnt0_strobe: got %b%b want 11", nd, na); end
        checks++; if (r !== 16'hA5A5) begin errors++; $display("FAIL cnt0_r: got %h want a5a5", r); end
    endtask

    task automatic test_load_wins();
        load(16'h1111);
        bus.ibus_in = 16'h5555; bus.nwrite_alu_b = 1'b0;
        bus.mode = SRU_SHL; bus.count = 5'd1; bus.naction_sru = 1'b0;
        tick();
        bus.nwrite_alu_b = 1'b1; bus.naction_sru = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ldwin_busy: got %b want 0", bus.busy); end
        tick();
        checks++; if (bus.ibus_out !== 16'h5555) begin errors++; $display("FAIL ldwin_r: got %h want 5555", bus.ibus_out); end
        checks++; if (bus.nflagwe_sru !== 1'b1) begin errors++; $display("FAIL ldwin_strobe: got %b want 1", bus.nflagwe_sru); end
    endtask

    task automatic test_mode_1xx();
        int cyc; logic nd, na, fo; logic [15:0] r;
        load(16'h8004);
        do_op(3'b100, 5'd2, 1'b1, cyc, nd, na, r, fo);
`ifdef ALU_SRU_ASR_EN
        checks++; if (r !== 16'hE001) begin errors++; $display("FAIL asr_r: got %h want e001", r); end
        checks++; if (fo !== 1'b0) begin errors++; $display("FAIL asr_flin: got %b want 0", fo); end
        checks++; if (nd !== 1'b0) begin errors++; $display("FAIL asr_strobe: got %b want 0", nd); end
        load(16'h8004);
`else
        checks++; if (r !== 16'h8004) begin errors++; $display("FAIL m100_r: got %h want 8004", r); end
        checks++; if (cyc !== 0 || nd !== 1'b1) begin errors++; $display("FAIL m100_strobe: got busy %0d nflagwe %b want 0 1", cyc, nd); end
`endif
        do_op(3'b101, 5'd3, 1'b1, cyc, nd, na, r, fo);
        checks++; if (r !== 16'h8004 || cyc !== 0 || nd !== 1'b1) begin errors++; $display("FAIL m101: got r %h busy %0d nflagwe %b want 8004 0 1", r, cyc, nd); end
    endtask

    task automatic test_reset_mid_run();
        load(16'h00FF);
        start(SRU_SHL, 5'd8, 1'b0);
        tick(); tick(); tick();
        checks++; if (bus.ibus_out !== 16'h07F8) begin errors++; $display("FAIL mid_partial: got %h want 07f8", bus.ibus_out); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.ibus_out !== 16'h0000) begin errors++; $display("FAIL mid_r: got %h want 0000", bus.ibus_out); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.nflagwe_sru !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_after: got nflagwe %b busy %b want 1 0", bus.nflagwe_sru, bus.busy); end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.ibus_in      = '0;
        bus.nwrite_alu_b = 1'b1;
        bus.naction_sru  = 1'b1;
        bus.count        = '0;
        bus.mode         = '0;
        bus.fl           = 1'b0;
        bus.nread_alu_b  = 1'b1;
        test_reset();
        test_shl();
        test_shr();
        test_ror();
        test_rol17();
        test_shl_saturate();
        test_ignore_and_back_to_back();
        test_count_zero();
        test_load_wins();
        test_mode_1xx();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
